chunked_adder_seq: RTL and testbench

CHUNKED_ADDER_SEQ -- requirements
Module: chunked_adder_seq

---
 rtl/chunked_adder_seq_pkg.sv | 13 +
 rtl/chunked_adder_seq_adder3.sv | 13 +
 rtl/chunked_adder_seq.sv | 119 +++++++++++
 tb/tb_chunked_adder_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_seq_pkg.sv
// Shared types and constants for the chunked sequential adder.
`timescale 1ns/1ps
package chunked_adder_seq_pkg;

    localparam int unsigned CHUNK_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunked_adder_seq_adder3.sv
// 3-bit ripple slice adder with carry in/out.
`timescale 1ns/1ps
module adder3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       cin,
    output logic [2:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {3'b000, cin};

endmodule

// File: rtl/chunked_adder_seq.sv
// Sequential adder: adds WIDTH-bit operands one 3-bit slice per cycle
// through a single shared slice adder, with valid/ready on both sides.
`timescale 1ns/1ps
module chunked_adder_seq
    import chunked_adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SEL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic [SEL_W-1:0]   base;
    logic [CHUNK_W-1:0] slice_a;
    logic [CHUNK_W-1:0] slice_b;
    logic [CHUNK_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_chunk;

    assign base       = SEL_W'(idx) * SEL_W'(CHUNK_W);
    assign slice_a    = op_a[base +: CHUNK_W];
    assign slice_b    = op_b[base +: CHUNK_W];
    assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

    adder3 u_adder3 (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Handshake flags are registered alongside the state so they change
    // exactly on the transition edge and clear immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            carry       <= 1'b0;
            idx         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a       <= a;
                        op_b       <= b;
                        carry      <= cin;
                        idx        <= '0;
                        state      <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_r[base +: CHUNK_W] <= slice_sum;
                    carry                  <= slice_cout;
                    idx                    <= idx + 1'b1;
                    if (last_chunk) begin
                        cout_r      <= slice_cout;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Scoreboard bench for chunked_adder_seq at WIDTH=12.
`timescale 1ns/1ps
module tb_chunked_adder_seq;

    localparam int unsigned W       = 12;
    localparam int unsigned NCH     = W / 3;
    localparam int          TIMEOUT = 50;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    chunked_adder_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        exp_t       e;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.s = t[W-1:0];
        e.c = t[W];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_, tc));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < TIMEOUT) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        n_checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h, required 1 0 0 0 000",
                     in_ready, out_valid, busy, cout, sum);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[2];
        logic [W-1:0] vb[2];
        logic         vc[2];
        int           cyc;
        exp_t         e;
        va[0] = 12'h123; vb[0] = 12'h456; vc[0] = 1'b1;
        va[1] = 12'hFFF; vb[1] = 12'h001; vc[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], vc[i]);
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL directed%0d_run_flags: busy=%b in_ready=%b, required 1 0", i, busy, in_ready);
            end
            wait_out(cyc);
            n_checks++;
            if (cyc !== NCH) begin
                n_fail++;
                $display("FAIL directed%0d_latency: got %0d cycles, required %0d", i, cyc, NCH);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (sum !== e.s || cout !== e.c) begin
                n_fail++;
                $display("FAIL directed%0d_result: sum=%h cout=%b, required sum=%h cout=%b", i, sum, cout, e.s, e.c);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_hold();
        int   cyc;
        exp_t e;
        start_op(12'hA5C, 12'h3B7, 1'b1);
        wait_out(cyc);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            a        = W'($urandom());
            b        = W'($urandom());
            cin      = $urandom_range(0, 1) == 1;
            in_valid = ~in_valid;
            tick();
            n_checks++;
            if (sum !== e.s || cout !== e.c || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: sum=%h cout=%b in_ready=%b out_valid=%b, required sum=%h cout=%b 0 1",
                         i, sum, cout, in_ready, out_valid, e.s, e.c);
            end
        end
        // Request held high through the consume edge must not be taken.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sum !== e.s || cout !== e.c) begin
            n_fail++;
            $display("FAIL hold_consume: in_ready=%b busy=%b out_valid=%b sum=%h cout=%b, required 1 0 0 %h %b",
                     in_ready, busy, out_valid, sum, cout, e.s, e.c);
        end
    endtask

    task automatic test_reset_mid_run();
        int   cyc;
        exp_t e;
        start_op(12'hABC, 12'h321, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h, required 1 0 0 0 000",
                     in_ready, out_valid, busy, cout, sum);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_op(12'h007, 12'h001, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_first_accept: busy=%b, required 1", busy);
        end
        wait_out(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== NCH || sum !== e.s || cout !== e.c) begin
            n_fail++;
            $display("FAIL midrun_next_op: cycles=%0d sum=%h cout=%b, required %0d %h %b", cyc, sum, cout, NCH, e.s, e.c);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   n_acc;
        int   n_res;
        int   last_acc;
        bit   accepting;
        exp_t e;
        cyc = 0; n_acc = 0; n_res = 0; last_acc = 0;
        a = W'($urandom()); b = W'($urandom()); cin = $urandom_range(0, 1) == 1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (n_res < 3 && cyc < 200) begin
            accepting = 1'b0;
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_res++;
                n_checks++;
                if (sum !== e.s || cout !== e.c) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: sum=%h cout=%b, required sum=%h cout=%b", n_res, sum, cout, e.s, e.c);
                end
            end
            if (in_ready === 1'b1 && in_valid) begin
                exp_q.push_back(model(a, b, cin));
                accepting = 1'b1;
                n_acc++;
                // accept edge + NCH RUN cycles + one DONE + one IDLE
                if (n_acc > 1) begin
                    n_checks++;
                    if (cyc - last_acc !== NCH + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: accepts %0d cycles apart, required %0d", cyc - last_acc, NCH + 2);
                    end
                end
                last_acc = cyc;
            end
            tick();
            cyc++;
            if (accepting) begin
                a = W'($urandom()); b = W'($urandom()); cin = $urandom_range(0, 1) == 1;
                if (n_acc == 3) in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_res !== 3) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d results, required 3", n_res);
        end
    endtask

    task automatic test_random();
        int   cyc;
        int   n_iss;
        int   n_res;
        int   n_bad;
        exp_t e;
        cyc = 0; n_iss = 0; n_res = 0; n_bad = 0;
        exp_q.delete();
        while (n_res < 1000 && cyc < 40000) begin
            in_valid  = (n_iss < 1000) && ($urandom_range(0, 3) != 0);
            a         = W'($urandom());
            b         = W'($urandom());
            cin       = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                e = exp_q.pop_front();
                n_res++;
                n_checks++;
                if (sum !== e.s || cout !== e.c) begin
                    n_fail++;
                    n_bad++;
                    if (n_bad <= 10)
                        $display("FAIL random_result%0d: sum=%h cout=%b, required sum=%h cout=%b", n_res, sum, cout, e.s, e.c);
                end
            end
            if (in_ready === 1'b1 && in_valid) begin
                exp_q.push_back(model(a, b, cin));
                n_iss++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_res !== 1000 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL random_completion: results=%0d pending=%0d, required 1000 0", n_res, exp_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded 5 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
